lsu: RTL

Load/store unit for the memory stage of the RV32I pipeline. It takes one access per request from the EX/MEM stage and drives a word-wide data bus with byte enables. It waits for the bus acknowledge, then returns sign/zero-extended load data that feeds the write-back select mux (`mux4to1`). While an access is outstanding it stalls the pipeline.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_ld_align.sv | 36 +++
 rtl/lsu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents: the FSM state enum, the RV32I funct3 width codes, the access
// legality check, and the store/load byte-lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is supported for this direction and the address is
    // naturally aligned for the access size.
    function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !we;
            F3_H:    ok = !lo[0];
            F3_HU:   ok = !we && !lo[0];
            F3_W:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables. Bits [1:0] of funct3 encode the size for loads and stores alike.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so that any byte enable picks it up.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load lane select and extension (combinational).
// Ports:
//   funct3  - latched RV32I load width/sign code
//   addr_lo - latched byte offset within the word
//   word    - raw bus read word
//   data    - lane-selected, sign- or zero-extended load result
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit for the RV32I memory stage.
// Takes one access per request, drives a word-wide bus with byte enables,
// waits for the acknowledge (or times out), then pulses o_done for one cycle.
// Ports:
//   i_clk, i_rst                   - clock, synchronous active-high reset
//   i_req/i_we/i_funct3/i_addr/i_wdata - access request from EX/MEM
//   o_busy                         - pipeline stall (combinational)
//   o_done/o_rdata/o_bad_access/o_timeout - registered completion info
//   o_bus_*/i_bus_ack/i_bus_rdata  - data bus
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_bad_access,
    output logic        o_timeout,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             we_q, we_n;
    logic [2:0]       f3_q, f3_n;
    logic [1:0]       lo_q, lo_n;

    logic        done_n, bad_n, to_n, bus_req_n, bus_we_n;
    logic [31:0] rdata_n, bus_addr_n, bus_wdata_n, ld_data;
    logic [3:0]  bus_be_n;

    lsu_ld_align u_ld_align (
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .word    (i_bus_rdata),
        .data    (ld_data)
    );

    // Stall while a request is being accepted or the bus access is outstanding.
    assign o_busy = ((state == ST_IDLE) && i_req) || (state == ST_BUS);

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        we_n        = we_q;
        f3_n        = f3_q;
        lo_n        = lo_q;
        done_n      = 1'b0;
        bad_n       = 1'b0;
        to_n        = 1'b0;
        rdata_n     = o_rdata;
        bus_req_n   = o_bus_req;
        bus_we_n    = o_bus_we;
        bus_addr_n  = o_bus_addr;
        bus_wdata_n = o_bus_wdata;
        bus_be_n    = o_bus_be;

        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    we_n = i_we;
                    f3_n = i_funct3;
                    lo_n = i_addr[1:0];
                    if (access_ok(i_we, i_funct3, i_addr[1:0])) begin
                        bus_req_n   = 1'b1;
                        bus_we_n    = i_we;
                        bus_addr_n  = {i_addr[31:2], 2'b00};
                        bus_wdata_n = lane_wdata(i_funct3, i_wdata);
                        bus_be_n    = lane_be(i_funct3, i_addr[1:0]);
                        cnt_n       = '0;
                        state_n     = ST_BUS;
                    end else begin
                        done_n  = 1'b1;
                        bad_n   = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end
            ST_BUS: begin
                // An ack in the final allowed cycle takes priority over the timeout.
                if (i_bus_ack) begin
                    bus_req_n = 1'b0;
                    done_n    = 1'b1;
                    state_n   = ST_RESP;
                    if (!we_q) begin
                        rdata_n = ld_data;
                    end
                end else if (cnt == CNT_LAST) begin
                    bus_req_n = 1'b0;
                    done_n    = 1'b1;
                    to_n      = 1'b1;
                    state_n   = ST_RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            lo_q         <= 2'b00;
            o_done       <= 1'b0;
            o_bad_access <= 1'b0;
            o_timeout    <= 1'b0;
            o_rdata      <= 32'h0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= 32'h0;
            o_bus_wdata  <= 32'h0;
            o_bus_be     <= 4'h0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            we_q         <= we_n;
            f3_q         <= f3_n;
            lo_q         <= lo_n;
            o_done       <= done_n;
            o_bad_access <= bad_n;
            o_timeout    <= to_n;
            o_rdata      <= rdata_n;
            o_bus_req    <= bus_req_n;
            o_bus_we     <= bus_we_n;
            o_bus_addr   <= bus_addr_n;
            o_bus_wdata  <= bus_wdata_n;
            o_bus_be     <= bus_be_n;
        end
    end

endmodule
